async_fifo_lvl: RTL and testbench
=================================

# async_fifo_lvl

Parametrised asynchronous (dual-clock) FIFO for crossing data between a write clock domain and a read clock domain. It carries Gray-coded pointers across the boundary through a configurable synchroniser depth. Each side gets a fill-level count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. A mode parameter selects first-word-fall-through or standard registered-read output. It is the general CDC buffer for core-to-peripheral and trace paths where the two clocks are unrelated.

## Interface
- WA, 8: address width; depth = 2**WA entries (WA >= 2).
- WD, 32: data width.
- SYNC, 2: synchroniser flops per pointer crossing (legal 2..4).
- AFULL, 2**WA-4: walmost_full asserts when wcount >= AFULL (1..2**WA).
- AEMPTY, 4: ralmost_empty asserts when rcount <= AEMPTY (0..2**WA-1).
- FWFT, 1: 1 = first-word-fall-through; 0 = standard read (data one rclk after ren).

Ports:
- rst  in  1  reset, asynchronous, active-high; clears both domains.
- wclk  in  1  write clock.
- rclk  in  1  read clock, unrelated to wclk.
- wen  in  1  write request (wclk).
- wdat  in  WD  write data.
- wfull  out  1  FIFO full (wclk).
- walmost_full  out  1  wcount >= AFULL.
- wcount  out  WA+1  write-side fill level, 0..2**WA.
- wovf  out  1  sticky: wen seen while wfull.
- ren  in  1  read request (rclk).
- rdat  out  WD  read data.
- rempty  out  1  FIFO empty (rclk).
- ralmost_empty  out  1  rcount <= AEMPTY.
- rcount  out  WA+1  read-side fill level, 0..2**WA.
- rudf  out  1  sticky: ren seen while rempty.

## Operation
- Storage: 2**WA x WD dual-port RAM, written on wclk, read on rclk. RAM contents are not reset.
- Pointers: WA+1-bit binary plus Gray copy in each domain. The extra MSB is the wrap bit. Binary increments modulo 2**(WA+1). The Gray copy is registered, and only the registered Gray copy crosses domains, through SYNC flops reset to 0.
- Write accept = wen & ~wfull. Read accept = ren & ~rempty. A rejected request changes no pointer, count or data.
- wcount = wbin_next - bin(rgray_sync), modulo 2**(WA+1). It is registered. Same scheme for rcount using the synchronised write pointer.
- wfull = (wcount == 2**WA). rempty = (rcount == 0). In FWFT mode, rempty additionally covers "output register not yet loaded".
- Counts are conservative. The write side may over-report fill and the read side may under-report it, but neither is ever wrong in the unsafe direction. No write ever overwrites unread data. No read ever returns an unwritten word.
- FWFT=1: while rempty=0, rdat already holds the head word. A read accept pops it, and rdat shows the next word on the following rclk edge if one exists. Otherwise rempty rises on that edge.
- FWFT=0: a read accept at an rclk edge loads rdat with the head word on that edge. rdat holds its value otherwise.
- Sticky flags: wovf sets on wclk when wen & wfull, and rudf sets on rclk when ren & rempty. Both are cleared only by rst.
- Simultaneous read and write in the full or empty state are legal. Each side acts on its own registered flag.

## Timing
- Reset values: wfull 0, walmost_full 0 (1 if AFULL=0 is ever allowed; it is not), wcount 0, wovf 0, rempty 1, ralmost_empty 1, rcount 0, rudf 0, rdat 0. All pointers and sync flops are 0.
- Reset applied mid-traffic clears both domains immediately. The contents are discarded, and the first post-reset write lands at address 0.
- Write-side flags and wcount update on the wclk edge that accepts the write. Example: the 2**WA-th accepted write raises wfull on that edge, so the next wen is rejected.
- Read-side flags and rcount update on the rclk edge that accepts the read. Example: popping the last word raises rempty on that edge.
- Write-to-read latency: rempty falls at most SYNC+2 rclk edges after the accepting wclk edge in FWFT=0, and at most SYNC+3 in FWFT=1.
- Read-to-write release: wfull falls at most SYNC+2 wclk edges after the accepting rclk edge.
- Pointer wrap: the address uses the low WA bits. Full is detected by a difference of 2**WA, not by Gray bit inversion in the flag logic.

## Test plan
- Reset, then WA=4, SYNC=2, FWFT=1, wclk 10ns, rclk 13ns: write 0x00..0x0F -> wfull=1 and wcount=16 on the 16th write edge. The 17th wen keeps wcount=16 and sets wovf=1.
- Drain the full FIFO with continuous ren -> rdat=0x00..0x0F in order, rempty=1 on the edge popping 0x0F. One more ren sets rudf=1 and leaves rdat unchanged.
- Single write of 0xA5 into an empty FIFO -> rempty falls within SYNC+3 rclk edges with rdat=0xA5 (FWFT=1). With FWFT=0, rdat=0xA5 one rclk after ren.
- AFULL=12, AEMPTY=3: write 12 words -> walmost_full=1 on the 12th write edge. Read until rcount=3 -> ralmost_empty=1 on that edge.
- 10,000 random wen/ren cycles with rclk/wclk ratios 1:3, 1:1 and 3:1 across 5 pointer wraps -> the read stream equals the accepted write stream, wcount never drops below true occupancy, rcount never exceeds it, and wovf=rudf=0 when requests respect the flags.
- Assert rst for 1 rclk in the middle of a half-full burst -> all outputs return to their reset values. The next write of 0x3C is read back as 0x3C.

Source files
------------

// File: rtl/async_fifo_lvl.sv
// async_fifo_lvl: dual-clock FIFO with Gray-coded pointer crossing, fill-level
// counts on both sides, programmable almost-full/almost-empty flags, and sticky
// overflow/underflow flags. FWFT selects first-word-fall-through (1) or
// registered read (0) output.
//
// Ports:
//   rst            async active-high reset, clears both domains
//   wclk           write clock
//   rclk           read clock, unrelated to wclk
//   wen, wdat      write request and data (wclk)
//   wfull          FIFO full (wclk)
//   walmost_full   wcount >= AFULL
//   wcount         write-side fill level, 0..2**WA
//   wovf           sticky: wen seen while wfull
//   ren            read request (rclk)
//   rdat           read data
//   rempty         FIFO empty (rclk)
//   ralmost_empty  rcount <= AEMPTY
//   rcount         read-side fill level, 0..2**WA
//   rudf           sticky: ren seen while rempty
module async_fifo_lvl #(
  parameter int WA     = 8,
  parameter int WD     = 32,
  parameter int SYNC   = 2,
  parameter int AFULL  = 2**WA - 4,
  parameter int AEMPTY = 4,
  parameter int FWFT   = 1
) (
  input  logic          rst,
  input  logic          wclk,
  input  logic          rclk,
  input  logic          wen,
  input  logic [WD-1:0] wdat,
  output logic          wfull,
  output logic          walmost_full,
  output logic [WA:0]   wcount,
  output logic          wovf,
  input  logic          ren,
  output logic [WD-1:0] rdat,
  output logic          rempty,
  output logic          ralmost_empty,
  output logic [WA:0]   rcount,
  output logic          rudf
);

  localparam int PW = WA + 1;
  localparam logic [PW-1:0] DEPTH    = PW'(2**WA);
  localparam logic [PW-1:0] AFULL_L  = PW'(AFULL);
  localparam logic [PW-1:0] AEMPTY_L = PW'(AEMPTY);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [WD-1:0] mem [2**WA];

  // ---------------- write domain ----------------
  logic [PW-1:0]            wbin, wgray, wbin_nxt, wcount_nxt;
  logic [SYNC-1:0][PW-1:0]  rsync_w;
  logic [PW-1:0]            rgray;
  logic                     wacc;

  assign wacc       = wen & ~wfull;
  assign wbin_nxt   = wbin + PW'(wacc);
  // The synchronised read pointer lags, so this count can only over-report.
  assign wcount_nxt = wbin_nxt - gray2bin(rsync_w[SYNC-1]);

  always_ff @(posedge wclk) begin
    if (wacc) mem[wbin[WA-1:0]] <= wdat;
  end

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      wbin         <= '0;
      wgray        <= '0;
      rsync_w      <= '0;
      wcount       <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wovf         <= 1'b0;
    end else begin
      wbin         <= wbin_nxt;
      wgray        <= bin2gray(wbin_nxt);
      rsync_w      <= {rsync_w[SYNC-2:0], rgray};
      wcount       <= wcount_nxt;
      wfull        <= (wcount_nxt == DEPTH);
      walmost_full <= (wcount_nxt >= AFULL_L);
      if (wen & wfull) wovf <= 1'b1;
    end
  end

  // ---------------- read domain ----------------
  // rpop counts words handed to the consumer; it is the pointer the write side
  // sees, so a word sitting in the FWFT output register still occupies its slot.
  logic [PW-1:0]            rpop, rpop_nxt, wsync_bin, rcount_nxt;
  logic [SYNC-1:0][PW-1:0]  wsync_r;
  logic                     racc;

  assign racc       = ren & ~rempty;
  assign rpop_nxt   = rpop + PW'(racc);
  assign wsync_bin  = gray2bin(wsync_r[SYNC-1]);
  assign rcount_nxt = wsync_bin - rpop_nxt;

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      rpop          <= '0;
      rgray         <= '0;
      wsync_r       <= '0;
      rcount        <= '0;
      ralmost_empty <= 1'b1;
      rudf          <= 1'b0;
    end else begin
      rpop          <= rpop_nxt;
      rgray         <= bin2gray(rpop_nxt);
      wsync_r       <= {wsync_r[SYNC-2:0], wgray};
      rcount        <= rcount_nxt;
      ralmost_empty <= (rcount_nxt <= AEMPTY_L);
      if (ren & rempty) rudf <= 1'b1;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // rfetch runs ahead of rpop by one while the output register holds a
      // word; rempty doubles as "output register not loaded".
      logic [PW-1:0] rfetch;
      logic          load;

      assign load = (rempty | racc) & (wsync_bin != rfetch);

      always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
          rfetch <= '0;
          rdat   <= '0;
          rempty <= 1'b1;
        end else begin
          if (load) begin
            rdat   <= mem[rfetch[WA-1:0]];
            rfetch <= rfetch + PW'(1);
          end
          rempty <= ~(load | (~rempty & ~racc));
        end
      end
    end else begin : g_std
      always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
          rdat   <= '0;
          rempty <= 1'b1;
        end else begin
          if (racc) rdat <= mem[rpop[WA-1:0]];
          rempty <= (rcount_nxt == '0);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_async_fifo_lvl.sv
// Bench for async_fifo_lvl: table-driven fill, hand-written drain / latency /
// reset sequences, and randomized traffic against a queue-based model.
module tb_async_fifo_lvl;

  localparam int WA = 4;
  localparam int WD = 32;
  localparam int SYNC = 2;
  localparam int DEPTH = 16;

  logic          rst, wclk, rclk, wen, ren, ren0;
  logic [WD-1:0] wdat;
  logic          wfull, walmost_full, wovf, rempty, ralmost_empty, rudf;
  logic [WA:0]   wcount, rcount;
  logic [WD-1:0] rdat;
  logic          wfull0, walmost_full0, wovf0, rempty0, ralmost_empty0, rudf0;
  logic [WA:0]   wcount0, rcount0;
  logic [WD-1:0] rdat0;

  int whalf = 10;
  int rhalf = 13;
  int n_cmp = 0;
  int n_bad = 0;
  logic [WD-1:0] q[$];

  async_fifo_lvl #(.WA(WA), .WD(WD), .SYNC(SYNC), .AFULL(12), .AEMPTY(3), .FWFT(1)) u_dut (
    .rst(rst), .wclk(wclk), .rclk(rclk), .wen(wen), .wdat(wdat),
    .wfull(wfull), .walmost_full(walmost_full), .wcount(wcount), .wovf(wovf),
    .ren(ren), .rdat(rdat), .rempty(rempty), .ralmost_empty(ralmost_empty),
    .rcount(rcount), .rudf(rudf));

  async_fifo_lvl #(.WA(WA), .WD(WD), .SYNC(SYNC), .AFULL(12), .AEMPTY(3), .FWFT(0)) u_dut0 (
    .rst(rst), .wclk(wclk), .rclk(rclk), .wen(wen), .wdat(wdat),
    .wfull(wfull0), .walmost_full(walmost_full0), .wcount(wcount0), .wovf(wovf0),
    .ren(ren0), .rdat(rdat0), .rempty(rempty0), .ralmost_empty(ralmost_empty0),
    .rcount(rcount0), .rudf(rudf0));

  initial begin wclk = 0; forever #(whalf) wclk = ~wclk; end
  initial begin rclk = 0; forever #(rhalf) rclk = ~rclk; end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic          wen;
    logic [WD-1:0] wdat;
    logic [WA:0]   e_wcount;
    logic          e_wfull;
    logic          e_wafull;
    logic          e_wovf;
  } fill_vec_t;

  fill_vec_t fill_tab [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wfull"}, wfull, 0);
    chk({tag, "_walmost_full"}, walmost_full, 0);
    chk({tag, "_wcount"}, wcount, 0);
    chk({tag, "_wovf"}, wovf, 0);
    chk({tag, "_rempty"}, rempty, 1);
    chk({tag, "_ralmost_empty"}, ralmost_empty, 1);
    chk({tag, "_rcount"}, rcount, 0);
    chk({tag, "_rudf"}, rudf, 0);
    chk({tag, "_rdat"}, rdat, 0);
  endtask

  task automatic do_reset();
    wen = 0; ren = 0; ren0 = 0;
    rst = 1;
    #40;
    @(negedge wclk);
    #1 rst = 0;
    #2;
  endtask

  task automatic run_phase(input int wh, input int rh, input int ncyc);
    bit wdone;
    int rcyc;
    int limit;
    whalf = wh; rhalf = rh;
    wdone = 0;
    limit = ncyc * 8 + 200;
    fork
      begin
        for (int c = 0; c < ncyc; c++) begin
          @(negedge wclk);
          chk("rand_wcount_not_below_occ", (int'(wcount) >= q.size()), 1);
          if (!wfull && $urandom_range(3) != 0) begin
            wen = 1;
            wdat = $urandom;
            q.push_back(wdat);
          end else begin
            wen = 0;
          end
        end
        @(negedge wclk) wen = 0;
        wdone = 1;
      end
      begin
        rcyc = 0;
        while (!(wdone && q.size() == 0) && rcyc < limit) begin
          @(negedge rclk);
          rcyc++;
          chk("rand_rcount_not_above_occ", (int'(rcount) <= q.size()), 1);
          if (!rempty && (wdone || $urandom_range(1) != 0)) begin
            ren = 1;
            if (q.size() == 0) chk("rand_pop_of_empty_model", 1, 0);
            else chk("rand_rdat", rdat, q.pop_front());
          end else begin
            ren = 0;
          end
        end
        @(negedge rclk) ren = 0;
        chk("rand_drain_in_budget", (rcyc < limit), 1);
      end
    join
  endtask

  initial begin
    int e1, e0;
    rst = 1; wen = 0; ren = 0; ren0 = 0; wdat = '0;

    for (int i = 0; i < 16; i++) begin
      fill_tab[i].wen      = 1;
      fill_tab[i].wdat     = WD'(i);
      fill_tab[i].e_wcount = (WA+1)'(i + 1);
      fill_tab[i].e_wfull  = (i + 1 == DEPTH);
      fill_tab[i].e_wafull = (i + 1 >= 12);
      fill_tab[i].e_wovf   = 0;
    end
    fill_tab[16] = '{wen: 1, wdat: 32'hEE, e_wcount: 5'd16, e_wfull: 1, e_wafull: 1, e_wovf: 1};
    fill_tab[17] = '{wen: 0, wdat: 32'h0,  e_wcount: 5'd16, e_wfull: 1, e_wafull: 1, e_wovf: 1};

    #30 chk_reset("in_reset");
    #3 rst = 0;
    #2 chk_reset("after_reset");

    // fill to full and one beyond
    for (int i = 0; i < 18; i++) begin
      @(negedge wclk);
      wen = fill_tab[i].wen;
      wdat = fill_tab[i].wdat;
      @(posedge wclk);
      #1;
      chk($sformatf("fill%0d_wcount", i), wcount, fill_tab[i].e_wcount);
      chk($sformatf("fill%0d_wfull", i), wfull, fill_tab[i].e_wfull);
      chk($sformatf("fill%0d_walmost_full", i), walmost_full, fill_tab[i].e_wafull);
      chk($sformatf("fill%0d_wovf", i), wovf, fill_tab[i].e_wovf);
    end
    wen = 0;

    // drain with continuous ren
    for (int n = 0; n < 20; n++) begin
      @(negedge rclk);
      if (!rempty && rcount == 16) break;
    end
    chk("drain_ready_rcount", rcount, 16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d_rdat", k), rdat, k);
      chk($sformatf("drain%0d_rempty", k), rempty, 0);
      chk($sformatf("drain%0d_rcount", k), rcount, 16 - k);
      chk($sformatf("drain%0d_ralmost_empty", k), ralmost_empty, ((16 - k) <= 3));
      ren = 1;
      @(negedge rclk);
    end
    chk("drain_end_rempty", rempty, 1);
    chk("drain_end_rcount", rcount, 0);
    chk("drain_end_rdat", rdat, 32'h0F);
    chk("drain_end_rudf_clear", rudf, 0);
    @(negedge rclk);
    chk("underflow_rudf", rudf, 1);
    chk("underflow_rdat_held", rdat, 32'h0F);
    ren = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge wclk);
      if (!wfull && wcount == 0) break;
    end
    chk("release_wfull", wfull, 0);
    chk("release_wcount", wcount, 0);

    // single-word latency, both output modes
    do_reset();
    chk_reset("pre_a5");
    @(negedge wclk);
    wen = 1; wdat = 32'hA5;
    @(posedge wclk);
    fork begin #1 wen = 0; end join_none
    e1 = 0; e0 = 0;
    for (int n = 1; n <= SYNC + 3; n++) begin
      @(posedge rclk);
      #1;
      if (!rempty && e1 == 0) e1 = n;
      if (!rempty0 && e0 == 0) e0 = n;
    end
    chk("a5_fwft_latency_ok", (e1 >= 1 && e1 <= SYNC + 3), 1);
    chk("a5_std_latency_ok", (e0 >= 1 && e0 <= SYNC + 2), 1);
    chk("a5_fwft_rdat", rdat, 32'hA5);
    chk("a5_std_rdat_before_ren", rdat0, 0);
    @(negedge rclk) ren0 = 1;
    @(posedge rclk);
    #1;
    chk("a5_std_rdat_after_ren", rdat0, 32'hA5);
    @(negedge rclk) ren0 = 0;
    chk("a5_std_rempty_after_pop", rempty0, 1);
    @(negedge rclk);
    chk("a5_std_rdat_held", rdat0, 32'hA5);

    // randomized traffic at three clock ratios
    do_reset();
    q.delete();
    run_phase(10, 31, 3300);
    run_phase(10, 11, 3300);
    run_phase(10, 3, 3400);
    whalf = 10; rhalf = 13;
    @(negedge wclk);
    chk("rand_wovf", wovf, 0);
    chk("rand_rudf", rudf, 0);
    chk("rand_model_empty", q.size(), 0);

    // reset in the middle of a burst
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge wclk);
      wen = 1; wdat = WD'(32'h10 + i);
    end
    @(negedge rclk) rst = 1;
    #1 chk_reset("mid_in_reset");
    @(negedge rclk) wen = 0;
    #1 rst = 0;
    #1 chk_reset("mid_after_reset");
    @(negedge wclk);
    wen = 1; wdat = 32'h3C;
    @(negedge wclk) wen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge rclk);
      if (!rempty) break;
    end
    chk("post_reset_rempty", rempty, 0);
    chk("post_reset_rdat", rdat, 32'h3C);
    chk("post_reset_rcount", rcount, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
